// File: rtl/entity_pkg.sv
// Shared entity record layout for shot/asteroid controllers and the collision detector.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package entity_pkg;

    // Entity record layout: [33] valid, [25:16] y position, [15:6] x position.
    localparam int ENTITY_SIZE = 34;
    localparam int VALID_BIT   = 33;
    localparam int YPOS_HI     = 25;
    localparam int YPOS_LO     = 16;
    localparam int XPOS_HI     = 15;
    localparam int XPOS_LO     = 6;
    localparam int COORD_W     = XPOS_HI - XPOS_LO + 1;

    // Collision detector scan sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cd_state_t;

endpackage

// File: rtl/collision_detector_if.sv
// Bundles the collision detector's frame tick, entity arrays and delete/status outputs.
// Latency: n/a (wiring only).
// Backpressure: none; start is a pulse, and deletes are strobes that the controllers must accept.
interface collision_detector_if
    import entity_pkg::*;
#(
    parameter int SHOT_COUNT     = 10,
    parameter int ASTEROID_COUNT = 4
);
    localparam int SHOT_AW = $clog2(SHOT_COUNT);
    localparam int AST_AW  = $clog2(ASTEROID_COUNT);

    logic                                       start;
    logic [SHOT_COUNT-1:0][ENTITY_SIZE-1:0]     shots_data;
    logic [ASTEROID_COUNT-1:0][ENTITY_SIZE-1:0] asteroids_data;
    logic                                       busy;
    logic                                       done;
    logic                                       delete_shot;
    logic [SHOT_AW-1:0]                         shot_address;
    logic                                       delete_asteroid;
    logic [AST_AW-1:0]                          asteroid_address;
`ifdef COLLISION_SCORE_EN
    logic [15:0]                                score;
`endif

    // Frame source / delete consumer side.
    modport master (
        output start, shots_data, asteroids_data,
        input  busy, done, delete_shot, shot_address, delete_asteroid, asteroid_address
`ifdef COLLISION_SCORE_EN
        , input score
`endif
    );

    // Collision detector side.
    modport slave (
        input  start, shots_data, asteroids_data,
        output busy, done, delete_shot, shot_address, delete_asteroid, asteroid_address
`ifdef COLLISION_SCORE_EN
        , output score
`endif
    );

endinterface

// File: rtl/aabb_overlap.sv
// Combinational axis-aligned box overlap test between box A (A_SIZE edge) and box B (B_SIZE edge).
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
module aabb_overlap
    import entity_pkg::*;
#(
    parameter int A_SIZE = 2,
    parameter int B_SIZE = 16
) (
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    output logic               hit
);
    // One extra bit keeps the far edges from wrapping near the top of the coordinate range.
    localparam int EW = COORD_W + 1;

    logic [EW-1:0] a_x_lo, a_x_hi, a_y_lo, a_y_hi;
    logic [EW-1:0] b_x_lo, b_x_hi, b_y_lo, b_y_hi;

    assign a_x_lo = {1'b0, a_x};
    assign a_y_lo = {1'b0, a_y};
    assign b_x_lo = {1'b0, b_x};
    assign b_y_lo = {1'b0, b_y};
    assign a_x_hi = a_x_lo + EW'(A_SIZE - 1);
    assign a_y_hi = a_y_lo + EW'(A_SIZE - 1);
    assign b_x_hi = b_x_lo + EW'(B_SIZE - 1);
    assign b_y_hi = b_y_lo + EW'(B_SIZE - 1);

    // Inclusive edges: boxes that share a single pixel row/column count as touching.
    assign hit = (a_x_hi >= b_x_lo) && (a_x_lo <= b_x_hi) &&
                 (a_y_hi >= b_y_lo) && (a_y_lo <= b_y_hi);

endmodule

// File: rtl/collision_detector.sv
// Per-frame shot/asteroid collision scan over a snapshot; issues paired delete strobes. Optional hit score: COLLISION_SCORE_EN.
// Latency: one pair (or one skipped invalid shot) per cycle; strobe one cycle after the hitting pair; done after the last pair.
// Backpressure: none; start is ignored while busy, delete strobes are fire-and-forget.
module collision_detector
    import entity_pkg::*;
#(
    parameter int SHOT_COUNT     = 10,
    parameter int ASTEROID_COUNT = 4,
    parameter int AST_SIZE       = 16,
    parameter int SHOT_SIZE      = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    collision_detector_if.slave bus
);
    localparam int                SHOT_AW   = $clog2(SHOT_COUNT);
    localparam int                AST_AW    = $clog2(ASTEROID_COUNT);
    localparam logic [SHOT_AW-1:0] SHOT_LAST = SHOT_AW'(SHOT_COUNT - 1);
    localparam logic [AST_AW-1:0]  AST_LAST  = AST_AW'(ASTEROID_COUNT - 1);

    cd_state_t                                  state;
    logic [SHOT_COUNT-1:0][ENTITY_SIZE-1:0]     snap_shots;
    logic [ASTEROID_COUNT-1:0][ENTITY_SIZE-1:0] snap_asts;
    logic [SHOT_AW-1:0]                         s_idx;
    logic [AST_AW-1:0]                          a_idx;

    logic                busy_q;
    logic                done_q;
    logic                del_q;
    logic [SHOT_AW-1:0]  shot_addr_q;
    logic [AST_AW-1:0]   ast_addr_q;
`ifdef COLLISION_SCORE_EN
    logic [15:0]         score_q;
`endif

    logic [ENTITY_SIZE-1:0] cur_shot;
    logic [ENTITY_SIZE-1:0] cur_ast;
    logic                   boxes_touch;
    logic                   hit;
    logic                   shot_done;

    assign cur_shot = snap_shots[s_idx];
    assign cur_ast  = snap_asts[a_idx];

    aabb_overlap #(
        .A_SIZE (SHOT_SIZE),
        .B_SIZE (AST_SIZE)
    ) u_overlap (
        .a_x (cur_shot[XPOS_HI:XPOS_LO]),
        .a_y (cur_shot[YPOS_HI:YPOS_LO]),
        .b_x (cur_ast[XPOS_HI:XPOS_LO]),
        .b_y (cur_ast[YPOS_HI:YPOS_LO]),
        .hit (boxes_touch)
    );

    // Record bits outside valid/x/y carry controller-private data and play no part in collisions.
    logic unused_fields;
    assign unused_fields = ^{cur_shot[VALID_BIT-1:YPOS_HI+1], cur_shot[XPOS_LO-1:0],
                             cur_ast[VALID_BIT-1:YPOS_HI+1],  cur_ast[XPOS_LO-1:0]};

    // A hit needs both snapshot entries still alive; clearing valid on a hit enforces one kill per entity.
    assign hit       = cur_shot[VALID_BIT] && cur_ast[VALID_BIT] && boxes_touch;
    // The current shot is finished when it is dead, just scored, or has tried every asteroid.
    assign shot_done = !cur_shot[VALID_BIT] || hit || (a_idx == AST_LAST);

    // Scan sequencer: snapshot on start, walk shot/asteroid pairs, register strobes and done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            snap_shots  <= '0;
            snap_asts   <= '0;
            s_idx       <= '0;
            a_idx       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            del_q       <= 1'b0;
            shot_addr_q <= '0;
            ast_addr_q  <= '0;
`ifdef COLLISION_SCORE_EN
            score_q     <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            del_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        snap_shots <= bus.shots_data;
                        snap_asts  <= bus.asteroids_data;
                        s_idx      <= '0;
                        a_idx      <= '0;
                        busy_q     <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        del_q                          <= 1'b1;
                        shot_addr_q                    <= s_idx;
                        ast_addr_q                     <= a_idx;
                        snap_shots[s_idx][VALID_BIT]   <= 1'b0;
                        snap_asts[a_idx][VALID_BIT]    <= 1'b0;
`ifdef COLLISION_SCORE_EN
                        if (score_q != 16'hFFFF) begin
                            score_q <= score_q + 16'd1;
                        end
`endif
                    end
                    if (shot_done) begin
                        a_idx <= '0;
                        if (s_idx == SHOT_LAST) begin
                            done_q <= 1'b1;
                            state  <= DONE;
                        end else begin
                            s_idx <= s_idx + 1'b1;
                        end
                    end else begin
                        a_idx <= a_idx + 1'b1;
                    end
                end
                DONE: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.delete_shot      = del_q;
    assign bus.delete_asteroid  = del_q;
    assign bus.shot_address     = shot_addr_q;
    assign bus.asteroid_address = ast_addr_q;
`ifdef COLLISION_SCORE_EN
    assign bus.score            = score_q;
`endif

endmodule

// File: tb/tb_collision_detector.sv
// Directed-vector bench for collision_detector with a frame-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_collision_detector;
    import entity_pkg::*;

    localparam int SC        = 10;
    localparam int AC        = 4;
    localparam int AST_SIZE  = 16;
    localparam int SHOT_SIZE = 2;

    typedef logic [SC-1:0][ENTITY_SIZE-1:0] shots_t;
    typedef logic [AC-1:0][ENTITY_SIZE-1:0] asts_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    collision_detector_if #(.SHOT_COUNT(SC), .ASTEROID_COUNT(AC)) bus ();

    collision_detector #(
        .SHOT_COUNT     (SC),
        .ASTEROID_COUNT (AC),
        .AST_SIZE       (AST_SIZE),
        .SHOT_SIZE      (SHOT_SIZE)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model outputs for one frame, indexed by cycle number relative to the start cycle.
    bit exp_del [0:63];
    int exp_sa  [0:63];
    int exp_aa  [0:63];
    int exp_done;
    int exp_hits;
    int last_sa = 0;
    int last_aa = 0;
    int exp_score = 0;

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    function automatic logic [ENTITY_SIZE-1:0] ent(input bit v, input int x, input int y);
        logic [ENTITY_SIZE-1:0] e;
        e = '0;
        e[VALID_BIT]       = v;
        e[XPOS_HI:XPOS_LO] = x[9:0];
        e[YPOS_HI:YPOS_LO] = y[9:0];
        return e;
    endfunction

    // Box touch test straight from the geometry: inclusive edges, no wrap (plain int arithmetic).
    function automatic bit touch(input logic [ENTITY_SIZE-1:0] s, input logic [ENTITY_SIZE-1:0] a);
        int sx, sy, ax, ay;
        sx = int'(s[XPOS_HI:XPOS_LO]);
        sy = int'(s[YPOS_HI:YPOS_LO]);
        ax = int'(a[XPOS_HI:XPOS_LO]);
        ay = int'(a[YPOS_HI:YPOS_LO]);
        return (sx + SHOT_SIZE - 1 >= ax) && (sx <= ax + AST_SIZE - 1) &&
               (sy + SHOT_SIZE - 1 >= ay) && (sy <= ay + AST_SIZE - 1);
    endfunction

    // Frame model: each shot tries asteroids in order, first live touch wins, each costs one cycle.
    task automatic model_frame(input shots_t sh, input asts_t as);
        bit sv [SC];
        bit av [AC];
        int k;
        for (int i = 0; i < 64; i++) begin
            exp_del[i] = 1'b0;
            exp_sa[i]  = 0;
            exp_aa[i]  = 0;
        end
        exp_hits = 0;
        for (int i = 0; i < SC; i++) sv[i] = sh[i][VALID_BIT];
        for (int i = 0; i < AC; i++) av[i] = as[i][VALID_BIT];
        k = 1;
        for (int s = 0; s < SC; s++) begin
            if (!sv[s]) begin
                k++;
                continue;
            end
            for (int a = 0; a < AC; a++) begin
                if (av[a] && touch(sh[s], as[a])) begin
                    exp_del[k+1] = 1'b1;
                    exp_sa[k+1]  = s;
                    exp_aa[k+1]  = a;
                    av[a]        = 1'b0;
                    exp_hits++;
                    k++;
                    break;
                end
                k++;
            end
        end
        exp_done = k;
    endtask

    // Launch one frame and compare every output on every cycle through the cycle after done.
    task automatic run_frame(input string tag, input shots_t sh, input asts_t as,
                             input int xs1, input int xs2, input int chg, input shots_t alt);
        model_frame(sh, as);
        @(negedge clk);
        bus.shots_data     = sh;
        bus.asteroids_data = as;
        bus.start          = 1'b1;
        for (int k = 1; k <= exp_done + 1; k++) begin
            @(negedge clk);
            if (exp_del[k]) begin
                last_sa = exp_sa[k];
                last_aa = exp_aa[k];
                if (exp_score < 65535) exp_score++;
            end
            check($sformatf("%s busy c%0d", tag, k), int'(bus.busy), int'(k <= exp_done));
            check($sformatf("%s done c%0d", tag, k), int'(bus.done), int'(k == exp_done));
            check($sformatf("%s del_shot c%0d", tag, k), int'(bus.delete_shot), int'(exp_del[k]));
            check($sformatf("%s del_ast c%0d", tag, k), int'(bus.delete_asteroid), int'(exp_del[k]));
            check($sformatf("%s shot_addr c%0d", tag, k), int'(bus.shot_address), last_sa);
            check($sformatf("%s ast_addr c%0d", tag, k), int'(bus.asteroid_address), last_aa);
`ifdef COLLISION_SCORE_EN
            check($sformatf("%s score c%0d", tag, k), int'(bus.score), exp_score);
`endif
            bus.start = (k == xs1) || (k == xs2);
            if (k == chg) bus.shots_data = alt;
        end
        bus.start = 1'b0;
    endtask

    shots_t sh, alt, none_sh;
    asts_t  as;
    int     score_before;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start          = 1'b0;
        bus.shots_data     = '0;
        bus.asteroids_data = '0;
        none_sh            = '0;

        // Reset state.
        #1;
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        check("reset del_shot", int'(bus.delete_shot), 0);
        check("reset del_ast", int'(bus.delete_asteroid), 0);
        check("reset shot_addr", int'(bus.shot_address), 0);
        check("reset ast_addr", int'(bus.asteroid_address), 0);
`ifdef COLLISION_SCORE_EN
        check("reset score", int'(bus.score), 0);
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Direct hit: strobe in cycle 2, then nine skipped shots put done in cycle 11.
        sh = '0; as = '0;
        sh[0] = ent(1, 100, 100);
        as[0] = ent(1, 95, 90);
        model_frame(sh, as);
        check("direct model done cycle", exp_done, 11);
        check("direct model strobe c2", int'(exp_del[2]), 1);
        run_frame("direct", sh, as, -1, -1, -1, none_sh);

        // No overlap, all shots valid: 40 scan cycles, done in cycle 41.
        for (int i = 0; i < SC; i++) sh[i] = ent(1, 300, 300);
        for (int i = 0; i < AC; i++) as[i] = ent(1, 0, 300);
        model_frame(sh, as);
        check("nohit model done cycle", exp_done, 41);
        check("nohit model hits", exp_hits, 0);
        run_frame("nohit", sh, as, -1, -1, -1, none_sh);

        // Start while busy (mid-scan and in the done cycle) is ignored.
        run_frame("busystart", sh, as, 5, 41, -1, none_sh);

        // Edge inclusion on x, asteroid at (200,200).
        begin
            int xs   [5] = '{216, 215, 198, 199, 2};
            int axs  [5] = '{200, 200, 200, 200, 1020};
            int want [5] = '{0, 1, 0, 1, 0};
            for (int t = 0; t < 5; t++) begin
                sh = '0; as = '0;
                sh[0] = ent(1, xs[t], 200);
                as[0] = ent(1, axs[t], 200);
                model_frame(sh, as);
                check($sformatf("edge%0d model hits", t), exp_hits, want[t]);
                run_frame($sformatf("edge%0d", t), sh, as, -1, -1, -1, none_sh);
            end
        end

        // Double hit: shots 0 and 1 both touch asteroid 2; only shot 0 scores.
        sh = '0; as = '0;
        sh[0] = ent(1, 50, 50);
        sh[1] = ent(1, 52, 52);
        as[0] = ent(1, 500, 500);
        as[1] = ent(1, 600, 600);
        as[2] = ent(1, 45, 45);
        as[3] = ent(1, 700, 700);
        model_frame(sh, as);
        check("double model hits", exp_hits, 1);
        check("double model shot", exp_sa[4], 0);
        check("double model ast", exp_aa[4], 2);
        check("double model done cycle", exp_done, 16);
        run_frame("double", sh, as, -1, -1, -1, none_sh);

        // Three disjoint hits in one frame.
        sh = '0; as = '0;
        sh[0] = ent(1, 10, 10);
        sh[3] = ent(1, 300, 300);
        sh[7] = ent(1, 600, 600);
        as[0] = ent(1, 5, 5);
        as[1] = ent(1, 295, 295);
        as[2] = ent(1, 900, 900);
        as[3] = ent(1, 590, 590);
        model_frame(sh, as);
        check("triple model hits", exp_hits, 3);
        score_before = exp_score;
        run_frame("triple", sh, as, -1, -1, -1, none_sh);
`ifdef COLLISION_SCORE_EN
        check("triple score delta", int'(bus.score), score_before + 3);
`endif

        // Live shot data wiped mid-scan must not change the frame's result.
        alt = '0;
        run_frame("midchange", sh, as, -1, -1, 2, alt);

        // Reset asserted in cycle 10 of a full scan: outputs clear at once, nothing follows.
        for (int i = 0; i < SC; i++) sh[i] = ent(1, 300, 300);
        for (int i = 0; i < AC; i++) as[i] = ent(1, 0, 300);
        @(negedge clk);
        bus.shots_data     = sh;
        bus.asteroids_data = as;
        bus.start          = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        reset_n = 1'b0;
        #1;
        check("midreset busy", int'(bus.busy), 0);
        check("midreset done", int'(bus.done), 0);
        check("midreset del", int'(bus.delete_shot), 0);
        check("midreset shot_addr", int'(bus.shot_address), 0);
        check("midreset ast_addr", int'(bus.asteroid_address), 0);
        last_sa   = 0;
        last_aa   = 0;
        exp_score = 0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            check($sformatf("postreset quiet c%0d", k),
                  int'({bus.busy, bus.done, bus.delete_shot, bus.delete_asteroid}), 0);
        end

        // Normal operation resumes after the aborted scan.
        sh = '0; as = '0;
        sh[4] = ent(1, 400, 400);
        as[1] = ent(1, 390, 399);
        run_frame("afterreset", sh, as, -1, -1, -1, none_sh);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
